// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix loader: opcodes, size codes, widths,
// operand memory addresses, FSM state encoding and the element placement helper.
// The optional WAIT_CU watchdog is enabled by defining MATRIX_LOADER_TIMEOUT_EN.
package matrix_pkg;

    localparam int WORD_W = 200;
    localparam int ELEM_W = 8;

    localparam logic [2:0] OP_ADD       = 3'd0;
    localparam logic [2:0] OP_SUB       = 3'd1;
    localparam logic [2:0] OP_MMUL      = 3'd2;
    localparam logic [2:0] OP_SMUL      = 3'd3;
    localparam logic [2:0] OP_UNARY4    = 3'd4;
    localparam logic [2:0] OP_TRANSPOSE = 3'd5;
    localparam logic [2:0] OP_UNARY6    = 3'd6;
    localparam logic [2:0] OP_INVALID   = 3'd7;

    localparam logic [1:0] SIZE_2X2 = 2'd0;
    localparam logic [1:0] SIZE_3X3 = 2'd1;
    localparam logic [1:0] SIZE_4X4 = 2'd2;
    localparam logic [1:0] SIZE_5X5 = 2'd3;

    localparam logic [1:0] ADDR_INSTR  = 2'd0;
    localparam logic [1:0] ADDR_A      = 2'd1;
    localparam logic [1:0] ADDR_B      = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_INSTR,
        S_LOAD_A,
        S_WR_A,
        S_LOAD_B,
        S_WR_B,
        S_START,
        S_WAIT_CU
    } state_e;

    // MSB of the byte lane for element (row, col); rows are 40 bits apart.
    function automatic logic [7:0] elem_msb(input logic [2:0] row, input logic [2:0] col);
        return 8'd199 - (8'd40 * {5'd0, row}) - {2'd0, col, 3'd0};
    endfunction

    // Opcodes that load a B operand from the element stream (matrix or scalar).
    function automatic logic b_has_elems(input logic [2:0] op);
        return op <= OP_SMUL;
    endfunction

endpackage

// File: rtl/elem_packer.sv
// Packs a row-major element stream into a 200-bit operand frame.
// Holds the row/col counters, the frame register and the last-element flag;
// one instance serves both operands, cleared before each one is loaded.
module elem_packer
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              scalar,
    input  logic [1:0]        size,
    input  logic [ELEM_W-1:0] elem,
    output logic              last,
    output logic [WORD_W-1:0] frame
);

    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic [WORD_W-1:0] frame_q, frame_d;
    logic [2:0]        n_m1;
    logic [7:0]        msb;

    assign n_m1  = {1'b0, size} + 3'd1;
    assign msb   = elem_msb(row_q, col_q);
    assign last  = scalar || ((row_q == n_m1) && (col_q == n_m1));
    assign frame = frame_q;

    // Place each accepted element and advance the counters; stalls hold everything.
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        frame_d = frame_q;
        if (clear) begin
            row_d   = '0;
            col_d   = '0;
            frame_d = '0;
        end else if (load) begin
            if (scalar) begin
                frame_d[ELEM_W-1:0] = elem;
            end else begin
                frame_d[msb -: ELEM_W] = elem;
                if (last) begin
                    row_d = '0;
                    col_d = '0;
                end else if (col_q == n_m1) begin
                    col_d = '0;
                    row_d = row_q + 3'd1;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
        end
    end

    // Counter and frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            frame_q <= '0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Matrix loader: accepts a host command, streams operand elements into
// instruction / A / B frames in operand memory, then kicks the control unit
// and waits for its result-ready pulse.
// Define MATRIX_LOADER_TIMEOUT_EN to add a 16-bit watchdog on WAIT_CU.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_opcode,
    input  logic [1:0]        cmd_size,
    output logic              cmd_ready,
    input  logic              elem_valid,
    input  logic [ELEM_W-1:0] elem_data,
    output logic              elem_ready,
    output logic [1:0]        mem_address,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cu_start,
    input  logic              cu_ready,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; ready depends only on state, never on valid.

    state_e            state_q, state_d;
    logic [2:0]        opcode_q, opcode_d;
    logic [1:0]        size_q, size_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              pk_clear, pk_load, pk_scalar, pk_last;
    logic [WORD_W-1:0] pk_frame;
    logic [WORD_W-1:0] instr_frame;
`ifdef MATRIX_LOADER_TIMEOUT_EN
    logic [15:0]       wd_q, wd_d;
`endif

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign elem_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign cu_start   = (state_q == S_START);
    assign done       = done_q;
    assign error      = error_q;

    // Packer is cleared while the instruction and A frames are written.
    assign pk_clear  = (state_q == S_WR_INSTR) || (state_q == S_WR_A);
    assign pk_load   = elem_valid && elem_ready;
    assign pk_scalar = (state_q == S_LOAD_B) && (opcode_q == OP_SMUL);

    elem_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .clear  (pk_clear),
        .load   (pk_load),
        .scalar (pk_scalar),
        .size   (size_q),
        .elem   (elem_data),
        .last   (pk_last),
        .frame  (pk_frame)
    );

    // Instruction word: size in byte 0, opcode in byte 1.
    always_comb begin
        instr_frame       = '0;
        instr_frame[7:0]  = {6'b0, size_q};
        instr_frame[15:8] = {5'b0, opcode_q};
    end

    // Memory write port: only the three write states drive it; address 3 is never used.
    always_comb begin
        mem_wren    = 1'b0;
        mem_address = ADDR_INSTR;
        mem_data    = '0;
        case (state_q)
            S_WR_INSTR: begin
                mem_wren    = 1'b1;
                mem_address = ADDR_INSTR;
                mem_data    = instr_frame;
            end
            S_WR_A: begin
                mem_wren    = 1'b1;
                mem_address = ADDR_A;
                mem_data    = pk_frame;
            end
            S_WR_B: begin
                mem_wren    = 1'b1;
                mem_address = ADDR_B;
                mem_data    = pk_frame;
            end
            default: ;
        endcase
    end

    // Next-state logic for the transaction sequence.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        size_d   = size_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
`ifdef MATRIX_LOADER_TIMEOUT_EN
        wd_d     = (state_q == S_WAIT_CU) ? wd_q + 16'd1 : 16'd0;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_opcode == OP_INVALID) begin
                        error_d = 1'b1;
                    end else begin
                        opcode_d = cmd_opcode;
                        size_d   = cmd_size;
                        state_d  = S_WR_INSTR;
                    end
                end
            end
            S_WR_INSTR: state_d = S_LOAD_A;
            S_LOAD_A: begin
                if (pk_load && pk_last) state_d = S_WR_A;
            end
            S_WR_A: state_d = b_has_elems(opcode_q) ? S_LOAD_B : S_WR_B;
            S_LOAD_B: begin
                if (pk_load && pk_last) state_d = S_WR_B;
            end
            S_WR_B:  state_d = S_START;
            S_START: state_d = S_WAIT_CU;
            S_WAIT_CU: begin
                if (cu_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef MATRIX_LOADER_TIMEOUT_EN
                else if (wd_q == 16'hFFFE) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched command and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            size_q   <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef MATRIX_LOADER_TIMEOUT_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            size_q   <= size_d;
            done_q   <= done_d;
            error_q  <= error_d;
`ifdef MATRIX_LOADER_TIMEOUT_EN
            wd_q     <= wd_d;
`endif
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Testbench for matrix_loader: directed and randomized transactions checked
// against a frame-level reference model of the operand memory writes.
// Compile with MATRIX_LOADER_TIMEOUT_EN to also exercise the watchdog.
module tb_matrix_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic [2:0]   cmd_opcode;
    logic [1:0]   cmd_size;
    logic         cmd_ready;
    logic         elem_valid;
    logic [7:0]   elem_data;
    logic         elem_ready;
    logic [1:0]   mem_address;
    logic [199:0] mem_data;
    logic         mem_wren;
    logic         cu_start;
    logic         cu_ready;
    logic         busy;
    logic         done;
    logic         error;

    matrix_loader dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_opcode  (cmd_opcode),
        .cmd_size    (cmd_size),
        .cmd_ready   (cmd_ready),
        .elem_valid  (elem_valid),
        .elem_data   (elem_data),
        .elem_ready  (elem_ready),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .cu_start    (cu_start),
        .cu_ready    (cu_ready),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    // Clock
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [201:0] exp_q[$];
    logic [201:0] obs_q[$];
    int start_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int busy_cnt  = 0;
    int acc_cnt   = 0;
    logic [7:0] a_mem[25];
    logic [7:0] b_mem[25];

    // Monitor: record writes and count pulses on the falling edge.
    always @(negedge clk) begin
        if (mem_wren) obs_q.push_back({mem_address, mem_data});
        if (cu_start) start_cnt++;
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (busy) busy_cnt++;
        if (elem_valid && elem_ready) acc_cnt++;
    end

    // Reference model: element i of an n x n operand sits at row i/n, col i%n.
    function automatic logic [199:0] model_frame(input int n, input bit use_b);
        logic [199:0] f;
        f = '0;
        for (int i = 0; i < n * n; i++) begin
            int r;
            int c;
            r = i / n;
            c = i % n;
            f[199 - 40 * r - 8 * c -: 8] = use_b ? b_mem[i] : a_mem[i];
        end
        return f;
    endfunction

    function automatic int b_count(input logic [2:0] op, input int n);
        if (op <= 3'd2) return n * n;
        else if (op == 3'd3) return 1;
        else return 0;
    endfunction

    task automatic build_expected(input logic [2:0] op, input logic [1:0] sz);
        int n;
        n = int'(sz) + 2;
        exp_q.delete();
        exp_q.push_back({2'd0, 184'd0, 5'd0, op, 6'd0, sz});
        exp_q.push_back({2'd1, model_frame(n, 1'b0)});
        if (op <= 3'd2) exp_q.push_back({2'd2, model_frame(n, 1'b1)});
        else if (op == 3'd3) exp_q.push_back({2'd2, 192'd0, b_mem[0]});
        else exp_q.push_back({2'd2, 200'd0});
    endtask

    // Drivers
    task automatic send_cmd(input logic [2:0] op, input logic [1:0] sz);
        int cyc;
        cyc = 0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_size   = sz;
        while (!cmd_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL cmd_handshake: cmd_ready stayed %b, required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_elem(input logic [7:0] d, input int gap);
        int cyc;
        cyc = 0;
        elem_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        elem_valid = 1'b1;
        elem_data  = d;
        while (!elem_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!elem_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL elem_handshake: elem_ready stayed %b, required 1", elem_ready);
        end
        @(posedge clk); #1;
        elem_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        else if (mode == 1) return 1;
        else return int'($urandom_range(0, 3));
    endfunction

    // One full transaction with all checks; noise=1 offers a command and a
    // cu_ready pulse while busy, both of which must be ignored.
    task automatic run_txn(input logic [2:0] op, input logic [1:0] sz, input int gap_mode, input bit noise);
        int n, nb, s0, d0, e0, a0, cyc;
        n  = int'(sz) + 2;
        nb = b_count(op, n);
        build_expected(op, sz);
        obs_q.delete();
        s0 = start_cnt; d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
        send_cmd(op, sz);
        if (noise) begin
            cmd_valid  = 1'b1;
            cmd_opcode = 3'd1;
            cmd_size   = 2'd2;
            cu_ready   = 1'b1;
            @(posedge clk); #1;
            cu_ready   = 1'b0;
        end
        for (int i = 0; i < n * n; i++) send_elem(a_mem[i], pick_gap(gap_mode));
        for (int i = 0; i < nb; i++) send_elem(b_mem[i], pick_gap(gap_mode));
        elem_valid = 1'b1;
        elem_data  = 8'hAA;
        cyc = 0;
        while (start_cnt == s0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (start_cnt == s0) begin
            n_cmp++; n_bad++;
            $display("FAIL cu_start_wait: no cu_start within bound");
        end
        repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (elem_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL elem_ready_wait: got %b required 0", elem_ready);
        end
        n_cmp++;
        if ({busy, cmd_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL busy_wait: busy/cmd_ready got %b required 10", {busy, cmd_ready});
        end
        n_cmp++;
        if (done_cnt - d0 !== 0) begin
            n_bad++;
            $display("FAIL early_done: got %0d done pulses required 0", done_cnt - d0);
        end
        cmd_valid = 1'b0;
        cu_ready  = 1'b1;
        @(posedge clk); #1;
        cu_ready   = 1'b0;
        elem_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL done_pulse: done/busy got %b required 10", {done, busy});
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (start_cnt - s0 !== 1) begin
            n_bad++;
            $display("FAIL cu_start_count: got %0d required 1", start_cnt - s0);
        end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL done_count: got %0d required 1", done_cnt - d0);
        end
        n_cmp++;
        if (err_cnt - e0 !== 0) begin
            n_bad++;
            $display("FAIL error_count: got %0d required 0", err_cnt - e0);
        end
        n_cmp++;
        if (acc_cnt - a0 !== n * n + nb) begin
            n_bad++;
            $display("FAIL elem_accept_count: got %0d required %0d", acc_cnt - a0, n * n + nb);
        end
        n_cmp++;
        if (obs_q.size() !== 3) begin
            n_bad++;
            $display("FAIL write_count: got %0d required 3", obs_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_size = '0;
        elem_valid = 1'b0; elem_data = '0; cu_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({cmd_ready, busy, elem_ready, mem_wren, cu_start, done, error} !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 1000000",
                     {cmd_ready, busy, elem_ready, mem_wren, cu_start, done, error});
        end
        n_cmp++;
        if ({mem_address, mem_data} !== 202'd0) begin
            n_bad++;
            $display("FAIL reset_mem: got %h required 0", {mem_address, mem_data});
        end
    endtask

    task automatic test_add();
        for (int i = 0; i < 4; i++) begin
            a_mem[i] = 8'(i + 1);
            b_mem[i] = 8'(i + 5);
        end
        run_txn(3'd0, 2'd0, 0, 1'b0);
        n_cmp++;
        if ({obs_q[1][199:184], obs_q[1][159:144]} !== 32'h0102_0304) begin
            n_bad++;
            $display("FAIL add_a_rows: got %h required 01020304", {obs_q[1][199:184], obs_q[1][159:144]});
        end
    endtask

    task automatic test_transpose();
        logic [199:0] want;
        want = 200'h0102030405060708090a0b0c0d0e0f10111213141516171819;
        for (int i = 0; i < 25; i++) a_mem[i] = 8'(i + 1);
        run_txn(3'd5, 2'd3, 0, 1'b0);
        n_cmp++;
        if (obs_q[1][199:0] !== want) begin
            n_bad++;
            $display("FAIL transpose_a: got %h required %h", obs_q[1][199:0], want);
        end
    endtask

    task automatic test_scalar();
        for (int i = 0; i < 9; i++) a_mem[i] = 8'($urandom_range(0, 255));
        b_mem[0] = 8'hFE;
        run_txn(3'd3, 2'd1, 0, 1'b0);
        n_cmp++;
        if (obs_q[2] !== {2'd2, 200'hFE}) begin
            n_bad++;
            $display("FAIL scalar_b: got %h required %h", obs_q[2], {2'd2, 200'hFE});
        end
    endtask

    task automatic test_invalid_opcode();
        int e0, b0;
        obs_q.delete();
        e0 = err_cnt; b0 = busy_cnt;
        send_cmd(3'd7, 2'($urandom_range(0, 3)));
        n_cmp++;
        if (error !== 1'b1) begin
            n_bad++;
            $display("FAIL invalid_error: got %b required 1", error);
        end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (err_cnt - e0 !== 1) begin
            n_bad++;
            $display("FAIL invalid_error_len: got %0d cycles required 1", err_cnt - e0);
        end
        n_cmp++;
        if (obs_q.size() !== 0) begin
            n_bad++;
            $display("FAIL invalid_writes: got %0d required 0", obs_q.size());
        end
        n_cmp++;
        if (busy_cnt - b0 !== 0) begin
            n_bad++;
            $display("FAIL invalid_busy: got %0d busy cycles required 0", busy_cnt - b0);
        end
    endtask

    task automatic test_busy_ignored();
        for (int i = 0; i < 25; i++) begin
            a_mem[i] = 8'($urandom_range(0, 255));
            b_mem[i] = 8'($urandom_range(0, 255));
        end
        run_txn(3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), 2, 1'b1);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = 8'($urandom_range(0, 255));
            b_mem[i] = 8'($urandom_range(0, 255));
        end
        run_txn(3'd2, 2'd2, 1, 1'b0);
    endtask

    task automatic test_mid_reset();
        int d0;
        for (int i = 0; i < 9; i++) a_mem[i] = 8'($urandom_range(0, 255));
        obs_q.delete();
        d0 = done_cnt;
        send_cmd(3'd0, 2'd1);
        for (int i = 0; i < 3; i++) send_elem(a_mem[i], 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({cmd_ready, busy, elem_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL mid_reset_idle: got %b required 100", {cmd_ready, busy, elem_ready});
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_q.size() !== 1) begin
            n_bad++;
            $display("FAIL mid_reset_writes: got %0d required 1", obs_q.size());
        end
        n_cmp++;
        if (done_cnt - d0 !== 0) begin
            n_bad++;
            $display("FAIL mid_reset_done: got %0d required 0", done_cnt - d0);
        end
        for (int i = 0; i < 25; i++) b_mem[i] = 8'($urandom_range(0, 255));
        run_txn(3'd1, 2'd1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 25; i++) begin
                a_mem[i] = 8'($urandom_range(0, 255));
                b_mem[i] = 8'($urandom_range(0, 255));
            end
            run_txn(3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), 2, 1'b0);
        end
    endtask

`ifdef MATRIX_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int k, s0, d0, cyc;
        for (int i = 0; i < 4; i++) a_mem[i] = 8'($urandom_range(0, 255));
        s0 = start_cnt; d0 = done_cnt;
        send_cmd(3'd4, 2'd0);
        for (int i = 0; i < 4; i++) send_elem(a_mem[i], 0);
        cyc = 0;
        while (start_cnt == s0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!error && k < 70000);
        n_cmp++;
        if (k !== 65536) begin
            n_bad++;
            $display("FAIL timeout_latency: error after %0d cycles in WAIT_CU, required 65535", k - 1);
        end
        n_cmp++;
        if ({busy, done_cnt - d0 == 0} !== 2'b01) begin
            n_bad++;
            $display("FAIL timeout_state: busy=%b done pulses=%0d, required 0 and 0", busy, done_cnt - d0);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_transpose();
        test_scalar();
        test_invalid_opcode();
        test_busy_ignored();
        test_stall();
        test_mid_reset();
        test_random();
`ifdef MATRIX_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
